// File: rtl/wb_arbiter.sv
// wb_arbiter: serialises ALU (valid/ready) and load (always accepted) results
// into at most one one-hot register write per cycle; loads win, ALU overflow waits in a one-entry buffer.
module wb_arbiter #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 16,
    parameter int AW       = 4,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_alu_valid,
    output logic             o_alu_ready,
    input  logic [AW-1:0]    i_alu_dest,
    input  logic [WIDTH-1:0] i_alu_data,
    input  logic             i_mem_valid,
    input  logic [AW-1:0]    i_mem_dest,
    input  logic [WIDTH-1:0] i_mem_data,
    output logic [NREGS-1:0] o_reg_en,
    output logic [WIDTH-1:0] o_reg_data,
    output logic             o_hold_full,
    output logic [15:0]      o_wr_count
);
    typedef enum logic {EMPTY, HELD} state_t;
    state_t           r_state;
    logic [AW-1:0]    r_hold_dest;
    logic [WIDTH-1:0] r_hold_data;
    logic [NREGS-1:0] r_reg_en;
    logic [WIDTH-1:0] r_reg_data;
    logic [15:0]      r_wr_count;
    logic             w_alu_xfer;
    logic             w_issue;
    logic             w_commit;
    logic [AW-1:0]    w_dest;
    logic [WIDTH-1:0] w_data;
    logic [NREGS-1:0] w_onehot;

    assign o_alu_ready = (r_state == EMPTY) && !reset;
    assign w_alu_xfer  = i_alu_valid && o_alu_ready;
    assign o_hold_full = (r_state == HELD);
    assign o_reg_en    = r_reg_en;
    assign o_reg_data  = r_reg_data;
    assign o_wr_count  = r_wr_count;

    // Priority: load > held entry > live ALU transfer
    always_comb begin
        w_issue  = i_mem_valid || (r_state == HELD) || w_alu_xfer;
        w_dest   = i_mem_valid ? i_mem_dest : (r_state == HELD) ? r_hold_dest : i_alu_dest;
        w_data   = i_mem_valid ? i_mem_data : (r_state == HELD) ? r_hold_data : i_alu_data;
        w_commit = w_issue && (int'(w_dest) < NREGS) && !(ZERO_REG && w_dest == '0);
        w_onehot = NREGS'(1) << w_dest;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_hold_dest <= '0;
            r_hold_data <= '0;
            r_reg_en    <= '0;
            r_reg_data  <= '0;
            r_wr_count  <= '0;
        end else begin
            r_state <= (i_mem_valid && ((r_state == HELD) || w_alu_xfer)) ? HELD : EMPTY;
            if (i_mem_valid && w_alu_xfer) begin
                r_hold_dest <= i_alu_dest;
                r_hold_data <= i_alu_data;
            end
            r_reg_en <= w_commit ? w_onehot : '0;
            if (w_issue)
                r_reg_data <= w_data;
            if (w_commit)
                r_wr_count <= r_wr_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a queue-based writeback model checked every cycle.
module tb_wb_arbiter;
    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             alu_valid = 1'b0;
    logic             alu_ready;
    logic [AW-1:0]    alu_dest = '0;
    logic [WIDTH-1:0] alu_data = '0;
    logic             mem_valid = 1'b0;
    logic [AW-1:0]    mem_dest = '0;
    logic [WIDTH-1:0] mem_data = '0;
    logic [NREGS-1:0] reg_en;
    logic [WIDTH-1:0] reg_data;
    logic             hold_full;
    logic [15:0]      wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_dest(alu_dest), .i_alu_data(alu_data),
        .i_mem_valid(mem_valid), .i_mem_dest(mem_dest), .i_mem_data(mem_data),
        .o_reg_en(reg_en), .o_reg_data(reg_data), .o_hold_full(hold_full), .o_wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending ALU results wait in a FIFO; a load always takes the slot.
    typedef struct {logic [AW-1:0] d; logic [WIDTH-1:0] v;} wr_t;
    wr_t              q[$];
    bit               m_live = 0;
    logic [NREGS-1:0] m_en;
    logic [WIDTH-1:0] m_data;
    logic [15:0]      m_cnt;

    function automatic logic [NREGS-1:0] decode(input logic [AW-1:0] d);
        return (d != 0 && int'(d) < NREGS) ? NREGS'(1 << d) : '0;
    endfunction

    always @(posedge clk) begin
        wr_t w;
        bit  go;
        if (reset) begin
            q.delete();
            m_en = '0; m_data = '0; m_cnt = '0; m_live = 1;
        end else if (m_live) begin
            go = 1;
            if (mem_valid) begin
                w = '{mem_dest, mem_data};
                if (alu_valid && q.size() == 0) q.push_back('{alu_dest, alu_data});
            end else if (q.size() > 0) w = q.pop_front();
            else if (alu_valid) w = '{alu_dest, alu_data};
            else go = 0;
            m_en = go ? decode(w.d) : '0;
            if (go) m_data = w.v;
            if (m_en != 0) m_cnt = m_cnt + 16'd1;
        end
    end

    always @(negedge clk) if (m_live) begin
        check("model_en", 32'(reg_en), 32'(m_en));
        check("model_hold", 32'(hold_full), 32'(q.size() > 0));
        check("model_count", 32'(wr_count), 32'(m_cnt));
        check("model_ready", 32'(alu_ready), 32'(!reset && q.size() == 0));
        if (m_en != 0) check("model_data", 32'(reg_data), 32'(m_data));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [AW-1:0] d, input logic [WIDTH-1:0] x);
        alu_valid = v; alu_dest = d; alu_data = x;
    endtask

    task automatic set_mem(input logic v, input logic [AW-1:0] d, input logic [WIDTH-1:0] x);
        mem_valid = v; mem_dest = d; mem_data = x;
    endtask

    initial begin
        step(); step();
        check("rst_en", 32'(reg_en), 0);
        check("rst_hold", 32'(hold_full), 0);
        check("rst_count", 32'(wr_count), 0);
        check("rst_ready", 32'(alu_ready), 0);
        reset = 1'b0;
        #1 check("first_ready", 32'(alu_ready), 1);
        // single ALU write
        set_alu(1, 4'd3, 16'hBEEF);
        step(); set_alu(0, 0, 0);
        check("alu_en", 32'(reg_en), 32'h08);
        check("alu_data", 32'(reg_data), 32'hBEEF);
        check("alu_count", 32'(wr_count), 1);
        // same-dest collision
        set_mem(1, 4'd5, 16'h1111); set_alu(1, 4'd5, 16'h2222);
        step(); set_mem(0, 0, 0); set_alu(0, 0, 0);
        check("col1_en", 32'(reg_en), 32'h20);
        check("col1_data", 32'(reg_data), 32'h1111);
        check("col1_hold", 32'(hold_full), 1);
        check("col1_ready", 32'(alu_ready), 0);
        step();
        check("col2_en", 32'(reg_en), 32'h20);
        check("col2_data", 32'(reg_data), 32'h2222);
        check("col2_hold", 32'(hold_full), 0);
        check("col2_ready", 32'(alu_ready), 1);
        // back-pressure: 3 load cycles, held entry, then stalled ALU entry
        set_mem(1, 4'd1, 16'h0101); set_alu(1, 4'd2, 16'h0202);
        step();
        check("bp_a_en", 32'(reg_en), 32'h02);
        set_mem(1, 4'd4, 16'h0404); set_alu(1, 4'd7, 16'hA5A5);
        step();
        check("bp_b_ready", 32'(alu_ready), 0);
        check("bp_b_data", 32'(reg_data), 32'h0404);
        set_mem(1, 4'd6, 16'h0606);
        step(); set_mem(0, 0, 0);
        check("bp_c_en", 32'(reg_en), 32'h40);
        check("bp_c_ready", 32'(alu_ready), 0);
        step();
        check("bp_d_en", 32'(reg_en), 32'h04);
        check("bp_d_data", 32'(reg_data), 32'h0202);
        check("bp_d_ready", 32'(alu_ready), 1);
        step(); set_alu(0, 0, 0);
        check("bp_e_en", 32'(reg_en), 32'h80);
        check("bp_e_data", 32'(reg_data), 32'hA5A5);
        check("bp_count", 32'(wr_count), 8);
        // dropped writes: r0 and out-of-range index
        set_alu(1, 4'd0, 16'h1234);
        step();
        check("drop0_en", 32'(reg_en), 0);
        check("drop0_count", 32'(wr_count), 8);
        set_alu(1, 4'd9, 16'h5678);
        step(); set_alu(0, 0, 0);
        check("drop9_en", 32'(reg_en), 0);
        check("drop9_count", 32'(wr_count), 8);
        // reset while an entry is held
        set_mem(1, 4'd3, 16'h3333); set_alu(1, 4'd4, 16'hDEAD);
        step(); set_mem(0, 0, 0); set_alu(0, 0, 0);
        check("mid_hold", 32'(hold_full), 1);
        reset = 1'b1;
        step();
        check("mid_en", 32'(reg_en), 0);
        check("mid_hold0", 32'(hold_full), 0);
        check("mid_count", 32'(wr_count), 0);
        check("mid_data", 32'(reg_data), 0);
        reset = 1'b0;
        step();
        check("mid_after_en", 32'(reg_en), 0);
        check("mid_after_data", 32'(reg_data), 0);
        // counter wrap
        for (int i = 0; i < 65536; i++) begin
            set_alu(1, 4'd1, 16'(i));
            step();
            if (i == 65534) check("wrap_ffff", 32'(wr_count), 32'hFFFF);
        end
        set_alu(0, 0, 0);
        check("wrap_zero", 32'(wr_count), 0);
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that sits directly upstream of the CPU's bank of 16-bit enable-gated registers. It accepts results from two producers: the ALU, via a valid/ready handshake, and the memory load path, which is always accepted. It serialises them into at most one register write per cycle. Each write is driven as a one-hot `reg_en` vector plus a shared `reg_data` bus, which fan out to every register's `enableReg`/`datain` pins.

## Interface
Parameters:
- `WIDTH`, 16: data width; matches register width.
- `NREGS`, 16: number of registers driven; `reg_en` width.
- `AW`, 4: destination index width; NREGS ≤ 2^AW.
- `ZERO_REG`, 0: if 1, writes to index 0 are dropped (r0 hardwired zero).

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `alu_valid` in 1: ALU result present.
- `alu_ready` out 1: arbiter can take an ALU result this cycle.
- `alu_dest` in AW: ALU destination register index.
- `alu_data` in WIDTH: ALU result.
- `mem_valid` in 1: load result present; never back-pressured.
- `mem_dest` in AW: load destination index.
- `mem_data` in WIDTH: load data.
- `reg_en` out NREGS: registered one-hot write enable, all-zero when idle.
- `reg_data` out WIDTH: registered write data.
- `hold_full` out 1: ALU hold buffer occupied.
- `wr_count` out 16: count of committed (non-dropped) writes; wraps.

## Operation
- **ALU handshake.** A transfer occurs when `alu_valid && alu_ready`. `alu_ready = !hold_full && !reset` (combinational from state). `alu_dest`/`alu_data` must stay stable while `alu_valid && !alu_ready`.
- **Hold buffer.** A one-entry buffer (dest + data) gives two states:
  - EMPTY → HELD: an ALU transfer occurs in the same cycle as `mem_valid`. The ALU entry is captured into the buffer.
  - HELD → EMPTY: a cycle with `!mem_valid`. The held entry issues.
  - HELD stays HELD: while `mem_valid` is high.
- **Issue priority, one write per cycle:** mem > held entry > live ALU transfer.
  - EMPTY, ALU transfer, no mem: ALU issues directly.
  - EMPTY, no inputs: idle; `reg_en` is 0 next cycle.
- **Destination decode.** `reg_en[d]` = 1 for the issued dest d. The write is dropped (`reg_en` all-zero; the slot is still consumed; `wr_count` is not incremented) if:
  - d ≥ NREGS, or
  - ZERO_REG=1 and d=0.
- **Same-dest collision.** If mem and ALU target the same register in the same cycle, mem writes first and ALU writes next cycle, so the final register value is the ALU data. This ordering is the defined behaviour.
- **Back-to-back mem.** Consecutive `mem_valid` cycles starve the held entry indefinitely. The load path guarantees a gap; the bench checks the entry is never lost or corrupted.
- **`wr_count`.** Increments by 1 per committed write; 0xFFFF+1 wraps to 0.
- **Reset.**
  - All outputs go to 0: `reg_en`=0, `reg_data`=0, `hold_full`=0, `wr_count`=0, `alu_ready`=0 while reset is high.
  - The hold buffer is emptied and its entry discarded.
  - Reset mid-operation discards any pending or held write; no partial write is emitted.

## Timing
- Inputs sampled at posedge N; `reg_en`/`reg_data` are valid during cycle N+1.
- The downstream register captures at posedge N+1, so input to register output takes 2 edges.
- A held ALU entry issues at the first edge where `mem_valid`=0.
- `alu_ready` rises in the cycle after the held entry issues.
- `hold_full` and `wr_count` are registered and update on the same edge as `reg_en`.
- Throughput: 1 write/cycle. The ALU sustains 1/cycle only while `mem_valid`=0.
- First cycle after reset deasserts: `alu_ready`=1, and an ALU transfer in that cycle is accepted.

## Test plan
- **Reset then single ALU write.** Reset 2 cycles; then `alu_valid`=1, dest=3, data=0xBEEF for 1 cycle → next cycle `reg_en`=0x0008, `reg_data`=0xBEEF; `wr_count`=1.
- **Collision.** `mem_valid` dest=5 data=0x1111 and `alu_valid` dest=5 data=0x2222 in the same cycle → cycle+1 `reg_en`=0x0020/0x1111, `hold_full`=1; cycle+2 `reg_en`=0x0020/0x2222, `hold_full`=0; `alu_ready` low in cycle+1, high in cycle+2.
- **Back-pressure.** Hold full, `mem_valid` held 3 cycles, ALU presents dest=7 data=0xA5A5 → `alu_ready`=0 throughout; the ALU entry is accepted only after the held entry drains; no write lost; `wr_count` advances by 5.
- **Dropped writes.** ZERO_REG=1, ALU dest=0 → `reg_en`=0 and `wr_count` unchanged. NREGS=8, dest=9 → same result.
- **Reset mid-operation.** With `hold_full`=1, assert reset 1 cycle → `reg_en`=0, `hold_full`=0, `wr_count`=0; the held data never appears on `reg_data`.
- **Wrap.** Force 65,536 committed writes → `wr_count` returns to 0x0000.
